// File: rtl/dot_product_pkg.sv
// ============================================================================
// dot_product_pkg : shared sizing helpers and pipeline sideband type
// Revision 1.0
// ============================================================================
`default_nettype none

package dot_product_pkg;

  typedef struct packed {
    logic valid;
    logic last;
    logic is_signed;
  } side_t;

  typedef struct packed {
    logic [63:0] max_v;
    logic [63:0] min_v;
  } bounds_t;

  function automatic int acc_size(input int in0, input int in1, input int lanes, input int ext);
    return in0 + in1 + $clog2(lanes) + ext;
  endfunction

  // Bounds are returned 64 bits wide; callers slice off their own width.
  function automatic bounds_t sat_bounds(input int width, input logic is_signed);
    bounds_t b;
    if (is_signed) begin
      b.max_v = (64'd1 << (width - 1)) - 64'd1;
      b.min_v = ~64'd0 << (width - 1);
    end else begin
      b.max_v = (64'd1 << width) - 64'd1;
      b.min_v = 64'd0;
    end
    return b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dot_product_tree.sv
// ============================================================================
// dot_product_tree : balanced combinational adder tree over lane products
// Revision 1.0
// ============================================================================
`default_nettype none

module dot_product_tree
  import dot_product_pkg::*;
#(
  parameter int PROD_W  = 12,
  parameter int N_LANES = 8,
  localparam int LEVELS = $clog2(N_LANES),
  localparam int SUM_W  = PROD_W + LEVELS
) (
  input  logic [N_LANES*PROD_W-1:0] prod_i,
  input  logic                      is_signed_i,
  output logic [SUM_W-1:0]          sum_o
);

  for (genvar lv = 0; lv <= LEVELS; lv++) begin : g_lvl
    localparam int CNT = N_LANES >> lv;
    logic [SUM_W-1:0] node [CNT];

    if (lv == 0) begin : g_leaf
      for (genvar l = 0; l < CNT; l++) begin : g_ext
        assign node[l] = {{LEVELS{is_signed_i & prod_i[l*PROD_W+PROD_W-1]}},
                          prod_i[l*PROD_W +: PROD_W]};
      end
    end else begin : g_sum
      for (genvar n = 0; n < CNT; n++) begin : g_add
        assign node[n] = g_lvl[lv-1].node[2*n] + g_lvl[lv-1].node[2*n+1];
      end
    end
  end

  assign sum_o = g_lvl[LEVELS].node[0];

endmodule

`default_nettype wire

// File: rtl/dot_product_acc.sv
// ============================================================================
// dot_product_acc : pipelined N-lane multiply-accumulate with frame output
// Revision 1.0
// ============================================================================
`default_nettype none

module dot_product_acc
  import dot_product_pkg::*;
#(
  parameter int IN_SIZE_0 = 4,
  parameter int IN_SIZE_1 = 8,
  parameter int N_LANES   = 8,
  parameter int ACC_EXT   = 8,
  parameter int SATURATE  = 1,
  localparam int ACC_SIZE = acc_size(IN_SIZE_0, IN_SIZE_1, N_LANES, ACC_EXT)
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           valid_i,
  output logic                           ready_o,
  input  logic [N_LANES*IN_SIZE_0-1:0]   in_0_i,
  input  logic [N_LANES*IN_SIZE_1-1:0]   in_1_i,
  input  logic                           signed_i,
  input  logic                           last_i,
  output logic                           out_valid_o,
  input  logic                           out_ready_i,
  output logic [ACC_SIZE-1:0]            out_o,
  output logic                           ovf_o
);

  localparam int      PW = IN_SIZE_0 + IN_SIZE_1;
  localparam int      SW = PW + $clog2(N_LANES);
  localparam bounds_t BS = sat_bounds(ACC_SIZE, 1'b1);
  localparam bounds_t BU = sat_bounds(ACC_SIZE, 1'b0);

  logic                    en;
  logic [N_LANES*PW-1:0]   prod_d, prod_q;
  logic [SW-1:0]           sum_d, sum_q;
  side_t                   side1_q, side2_q;
  logic [ACC_SIZE-1:0]     acc_q, acc_next;
  logic                    frame_open_q, sticky_q, ovf_beat;
  logic                    out_valid_q, ovf_q;
  logic [ACC_SIZE-1:0]     out_q;
  logic [ACC_SIZE-1:0]     base;
  logic [ACC_SIZE:0]       sum_ext, base_ext, tot;

  assign en      = !out_valid_q || out_ready_i;
  assign ready_o = en;

  // Operands are extended to the full product width so a plain modular
  // multiply yields the correct signed or unsigned product.
  for (genvar l = 0; l < N_LANES; l++) begin : g_lane
    logic [PW-1:0] a_ext, b_ext;
    assign a_ext = {{IN_SIZE_1{signed_i & in_0_i[l*IN_SIZE_0+IN_SIZE_0-1]}},
                    in_0_i[l*IN_SIZE_0 +: IN_SIZE_0]};
    assign b_ext = {{IN_SIZE_0{signed_i & in_1_i[l*IN_SIZE_1+IN_SIZE_1-1]}},
                    in_1_i[l*IN_SIZE_1 +: IN_SIZE_1]};
    assign prod_d[l*PW +: PW] = a_ext * b_ext;
  end

  dot_product_tree #(
    .PROD_W  (PW),
    .N_LANES (N_LANES)
  ) u_tree (
    .prod_i      (prod_q),
    .is_signed_i (side1_q.is_signed),
    .sum_o       (sum_d)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      side1_q <= '0;
      side2_q <= '0;
      prod_q  <= '0;
      sum_q   <= '0;
    end else if (en) begin
      side1_q <= side_t'{valid_i, valid_i & last_i, signed_i};
      prod_q  <= prod_d;
      side2_q <= side1_q;
      sum_q   <= sum_d;
    end
  end

  // One extra bit above the accumulator exposes carry / sign overflow.
  always_comb begin
    base     = frame_open_q ? acc_q : '0;
    sum_ext  = {{(ACC_SIZE+1-SW){side2_q.is_signed & sum_q[SW-1]}}, sum_q};
    base_ext = {side2_q.is_signed & base[ACC_SIZE-1], base};
    tot      = base_ext + sum_ext;
    ovf_beat = side2_q.is_signed ? (tot[ACC_SIZE] ^ tot[ACC_SIZE-1]) : tot[ACC_SIZE];
    acc_next = tot[ACC_SIZE-1:0];
    if (ovf_beat && (SATURATE != 0)) begin
      if (side2_q.is_signed)
        acc_next = tot[ACC_SIZE] ? BS.min_v[ACC_SIZE-1:0] : BS.max_v[ACC_SIZE-1:0];
      else
        acc_next = BU.max_v[ACC_SIZE-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q        <= '0;
      frame_open_q <= 1'b0;
      sticky_q     <= 1'b0;
      out_valid_q  <= 1'b0;
      out_q        <= '0;
      ovf_q        <= 1'b0;
    end else if (en) begin
      out_valid_q <= side2_q.valid & side2_q.last;
      if (side2_q.valid) begin
        acc_q        <= side2_q.last ? '0 : acc_next;
        frame_open_q <= !side2_q.last;
        sticky_q     <= !side2_q.last & (sticky_q | ovf_beat);
        if (side2_q.last) begin
          out_q <= acc_next;
          ovf_q <= sticky_q | ovf_beat;
        end
      end
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_o       = out_q;
  assign ovf_o       = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_dot_product_acc.sv
// ============================================================================
// tb_dot_product_acc : three configurations (wide/saturating, narrow
// saturating, narrow wrapping) driven in lockstep against a frame model
// ============================================================================
`default_nettype none

module tb_dot_product_acc;

  localparam int N = 8;
  localparam int A = 4;
  localparam int B = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n, valid, sgn, last, out_ready;
  logic [N*A-1:0] in0;
  logic [N*B-1:0] in1;
  logic [2:0]     rdy, ovld, ovf;
  logic [22:0]    out0;
  logic [14:0]    out1, out2;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [2:0][63:0] val;
    logic [2:0]       ovf;
  } exp_t;

  exp_t   mq[$];
  exp_t   lq[$];
  longint macc [3];
  bit     mstk [3];

  dot_product_acc #(.IN_SIZE_0(A), .IN_SIZE_1(B), .N_LANES(N), .ACC_EXT(8), .SATURATE(1)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid), .ready_o(rdy[0]), .in_0_i(in0), .in_1_i(in1),
    .signed_i(sgn), .last_i(last), .out_valid_o(ovld[0]), .out_ready_i(out_ready), .out_o(out0), .ovf_o(ovf[0]));

  dot_product_acc #(.IN_SIZE_0(A), .IN_SIZE_1(B), .N_LANES(N), .ACC_EXT(0), .SATURATE(1)) u_sat (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid), .ready_o(rdy[1]), .in_0_i(in0), .in_1_i(in1),
    .signed_i(sgn), .last_i(last), .out_valid_o(ovld[1]), .out_ready_i(out_ready), .out_o(out1), .ovf_o(ovf[1]));

  dot_product_acc #(.IN_SIZE_0(A), .IN_SIZE_1(B), .N_LANES(N), .ACC_EXT(0), .SATURATE(0)) u_wrap (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid), .ready_o(rdy[2]), .in_0_i(in0), .in_1_i(in1),
    .signed_i(sgn), .last_i(last), .out_valid_o(ovld[2]), .out_ready_i(out_ready), .out_o(out2), .ovf_o(ovf[2]));

  function automatic int width_of(input int i);
    return (i == 0) ? 23 : 15;
  endfunction

  function automatic longint out_of(input int i);
    case (i)
      0:       return longint'(out0);
      1:       return longint'(out1);
      default: return longint'(out2);
    endcase
  endfunction

  function automatic longint mask_of(input int i);
    return (longint'(1) << width_of(i)) - 1;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Frame model: plain integer dot product, range test, clamp or wrap.
  task automatic model_beat(input logic [N*A-1:0] a, input logic [N*B-1:0] b, input bit s, input bit l);
    longint dot;
    exp_t   e;
    dot = 0;
    e   = '0;
    for (int k = 0; k < N; k++) begin
      logic [A-1:0] av;
      logic [B-1:0] bv;
      longint ai, bi;
      av = a[k*A +: A];
      bv = b[k*B +: B];
      ai = s ? longint'($signed(av)) : longint'(av);
      bi = s ? longint'($signed(bv)) : longint'(bv);
      dot += ai * bi;
    end
    for (int i = 0; i < 3; i++) begin
      int     w;
      longint lo, hi, t;
      bit     o;
      w  = width_of(i);
      lo = s ? -(longint'(1) << (w - 1)) : 0;
      hi = s ? (longint'(1) << (w - 1)) - 1 : (longint'(1) << w) - 1;
      t  = macc[i] + dot;
      o  = (t < lo) || (t > hi);
      if (o) begin
        if (i != 2) begin
          t = (t > hi) ? hi : lo;
        end else begin
          t = t & mask_of(i);
          if (s && t > hi) t = t - (longint'(1) << w);
        end
      end
      if (l) begin
        e.val[i] = t;
        e.ovf[i] = mstk[i] | o;
        macc[i]  = 0;
        mstk[i]  = 1'b0;
      end else begin
        macc[i] = t;
        mstk[i] = mstk[i] | o;
      end
    end
    if (l) mq.push_back(e);
  endtask

  task automatic lit(input longint v0, input bit o0, input longint v1, input bit o1,
                     input longint v2, input bit o2);
    exp_t e;
    e.val[0] = v0; e.val[1] = v1; e.val[2] = v2;
    e.ovf    = {o2, o1, o0};
    lq.push_back(e);
  endtask

  task automatic send(input logic [N*A-1:0] a, input logic [N*B-1:0] b, input bit s, input bit l);
    int n;
    n = 0;
    in0 = a; in1 = b; sgn = s; last = l; valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!rdy[0] && n < 40);
    checks++;
    if (!rdy[0]) begin
      errors++;
      $display("FAIL send_timeout actual=ready_low required=ready_high at %0t", $time);
      valid = 1'b0;
      return;
    end
    @(posedge clk);
    model_beat(a, b, s, l);
    #1 valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [N*A-1:0] repa(input logic [A-1:0] v);
    return {N{v}};
  endfunction

  function automatic logic [N*B-1:0] repb(input logic [B-1:0] v);
    return {N{v}};
  endfunction

  // Per-cycle compare of all three instances against model and literal queues.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        for (int i = 0; i < 3; i++)
          chk($sformatf("ready_rule[%0d]", i), longint'(rdy[i]), longint'(!ovld[i] || out_ready));
        if (ovld[0]) begin
          if (mq.size() == 0 || lq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result actual=valid required=no_pending_frame at %0t", $time);
          end else begin
            for (int i = 0; i < 3; i++) begin
              chk($sformatf("valid[%0d]", i), longint'(ovld[i]), 1);
              chk($sformatf("model_out[%0d]", i), out_of(i), longint'(mq[0].val[i]) & mask_of(i));
              chk($sformatf("model_ovf[%0d]", i), longint'(ovf[i]), longint'(mq[0].ovf[i]));
              chk($sformatf("literal_out[%0d]", i), out_of(i), longint'(lq[0].val[i]) & mask_of(i));
              chk($sformatf("literal_ovf[%0d]", i), longint'(ovf[i]), longint'(lq[0].ovf[i]));
            end
            if (out_ready) begin
              void'(mq.pop_front());
              void'(lq.pop_front());
            end
          end
        end
      end
    end
  end

  logic [N*A-1:0] va7, va8, va9;
  logic [N*B-1:0] vb7, vb8, vb9;

  task automatic drain();
    int n;
    n = 0;
    while (mq.size() != 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_pending", longint'(mq.size()), 0);
  endtask

  initial begin
    rst_n = 1'b0; valid = 1'b0; out_ready = 1'b1; sgn = 1'b0; last = 1'b0;
    in0 = '0; in1 = '0;
    for (int i = 0; i < 3; i++) begin macc[i] = 0; mstk[i] = 1'b0; end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_valid[%0d]", i), longint'(ovld[i]), 0);
      chk($sformatf("rst_out[%0d]", i), out_of(i), 0);
      chk($sformatf("rst_ovf[%0d]", i), longint'(ovf[i]), 0);
      chk($sformatf("rst_ready[%0d]", i), longint'(rdy[i]), 1);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    idle(1);

    // Signed single beat with latency probe: -8 * -128 * 8 lanes = 8192.
    send(repa(4'h8), repb(8'h80), 1'b1, 1'b1);
    lit(8192, 0, 8192, 0, 8192, 0);
    @(negedge clk); chk("latency_edge_k", longint'(ovld[0]), 0);
    @(negedge clk); chk("latency_edge_k1", longint'(ovld[0]), 0);
    @(negedge clk); chk("latency_edge_k2", longint'(ovld[0]), 1);
    @(posedge clk); #1;

    // Back-to-back: unsigned 15*255*8 = 30600, signed 7*127*8 = 7112.
    send(repa(4'hF), repb(8'hFF), 1'b0, 1'b1);
    lit(30600, 0, 30600, 0, 30600, 0);
    send(repa(4'h7), repb(8'h7F), 1'b1, 1'b1);
    lit(7112, 0, 7112, 0, 7112, 0);
    @(negedge clk); @(negedge clk);
    chk("b2b_first", longint'(ovld[0]), 1);
    @(negedge clk);
    chk("b2b_second", longint'(ovld[0]), 1);
    @(posedge clk); #1;
    drain();

    // Four-beat frame with a bubble; narrow configs saturate / wrap.
    send(repa(4'h8), repb(8'h80), 1'b1, 1'b0);
    send(repa(4'h8), repb(8'h80), 1'b1, 1'b0);
    idle(1);
    send(repa(4'h8), repb(8'h80), 1'b1, 1'b0);
    send(repa(4'h8), repb(8'h80), 1'b1, 1'b1);
    lit(32768, 0, 16383, 1, 0, 1);
    drain();

    // Two beats of 8192 overflow the 15-bit accumulator; next frame is clean.
    send(repa(4'h8), repb(8'h80), 1'b1, 1'b0);
    send(repa(4'h8), repb(8'h80), 1'b1, 1'b1);
    lit(16384, 0, 16383, 1, -16384, 1);
    send(repa(4'h1), repb(8'h01), 1'b1, 1'b1);
    lit(8, 0, 8, 0, 8, 0);
    drain();

    // Backpressure: lane-indexed operands give 56, 28, -40, then -48.
    for (int k = 0; k < N; k++) begin
      va7[k*A +: A] = A'(k);  vb7[k*B +: B] = 8'd2;
      va8[k*A +: A] = 4'd1;   vb8[k*B +: B] = B'(k);
      va9[k*A +: A] = 4'hF;   vb9[k*B +: B] = 8'd5;
    end
    out_ready = 1'b0;
    fork
      begin
        send(va7, vb7, 1'b0, 1'b1); lit(56, 0, 56, 0, 56, 0);
        send(va8, vb8, 1'b0, 1'b1); lit(28, 0, 28, 0, 28, 0);
        send(va9, vb9, 1'b1, 1'b1); lit(-40, 0, -40, 0, -40, 0);
        send(repa(4'h3), repb(8'hFE), 1'b1, 1'b1); lit(-48, 0, -48, 0, -48, 0);
      end
      begin
        int n;
        n = 0;
        while (!ovld[0] && n < 30) begin
          @(negedge clk);
          n++;
        end
        chk("stall_result_seen", longint'(ovld[0]), 1);
        repeat (5) begin
          @(negedge clk);
          chk("stall_ready", longint'(rdy[0]), 0);
          chk("stall_hold_out", longint'(out0), 56);
        end
        @(posedge clk); #1 out_ready = 1'b1;
      end
    join
    drain();

    // Reset mid-frame discards the partial accumulation.
    send(repa(4'h7), repb(8'h7F), 1'b1, 1'b0);
    send(repa(4'h7), repb(8'h7F), 1'b1, 1'b0);
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin macc[i] = 0; mstk[i] = 1'b0; end
    repeat (3) begin
      @(negedge clk);
      chk("midrst_valid", longint'(ovld[0]), 0);
      chk("midrst_out", longint'(out0), 0);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    send(repa(4'h1), repb(8'h01), 1'b1, 1'b1);
    lit(8, 0, 8, 0, 8, 0);
    drain();
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
